// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding and
// board clock constants used to derive debounce/long-press cycle counts.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } key_fsm_e;

    localparam int CLK_FREQ_HZ   = 50_000_000;
    localparam int CYCLES_PER_MS = CLK_FREQ_HZ / 1000;

    function automatic int ms_to_cycles(input int ms);
        return ms * CYCLES_PER_MS;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for the asynchronous key pin plus one delay flop
// for edge detection; everything resets to the released (high) level.
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic s,
    output logic nedge,
    output logic pedge
);

    logic sync_q1;
    logic sync_q2;
    logic dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
            dly_q   <= sync_q2;
        end
    end

    assign s     = sync_q2;
    assign nedge = dly_q & ~sync_q2;
    assign pedge = ~dly_q & sync_q2;

endmodule

// File: rtl/key_debounce_fsm.sv
// Per-key conditioner: debounces the raw active-low pin and emits registered
// single-cycle press/release/long-press pulses plus a clean level.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | key released and stable
//   FILT_DN | falling edge seen, waiting for the low level to hold
//   DOWN    | press accepted, long-press timer running
//   FILT_UP | rising edge seen, waiting for the high level to hold
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int CNT_W             = 26
) (
    input  logic Clk,
    input  logic Rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic key_sync;
    logic key_nedge;
    logic key_pedge;

    key_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
    logic [CNT_W-1:0] long_inc;
    logic             key_state_d;
    logic             press_d;
    logic             release_d;
    logic             long_d;

    key_sync_edge u_sync (
        .clk    (Clk),
        .rst    (Rst),
        .key_in (key_in),
        .s      (key_sync),
        .nedge  (key_nedge),
        .pedge  (key_pedge)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            long_cnt_q  <= '0;
            key_state   <= 1'b1;
            key_flag    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            long_cnt_q  <= long_cnt_d;
            key_state   <= key_state_d;
            key_flag    <= press_d | release_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        long_cnt_d  = long_cnt_q;
        key_state_d = key_state;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        // Saturating hold timer: the single compare against LONG_LAST then
        // fires at most once per accepted press.
        long_inc    = (long_cnt_q == CNT_MAX) ? long_cnt_q : long_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (key_nedge) begin
                    state_d   = FILT_DN;
                    deb_cnt_d = '0;
                end
            end
            FILT_DN: begin
                deb_cnt_d = deb_cnt_q + 1'b1;
                // A bounce edge takes priority over the terminal count.
                if (key_pedge) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST && !key_sync) begin
                    state_d     = DOWN;
                    press_d     = 1'b1;
                    key_state_d = 1'b0;
                    long_cnt_d  = '0;
                end
            end
            DOWN: begin
                long_cnt_d = long_inc;
                if (long_cnt_q == LONG_LAST) begin
                    long_d = 1'b1;
                end
                if (key_pedge) begin
                    state_d   = FILT_UP;
                    deb_cnt_d = '0;
                end
            end
            FILT_UP: begin
                deb_cnt_d  = deb_cnt_q + 1'b1;
                long_cnt_d = long_inc;
                if (key_nedge) begin
                    state_d = DOWN;
                end else if (deb_cnt_q == DEB_LAST && key_sync) begin
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    key_state_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
